// File: rtl/vproc_pkg.sv
// Shared types for the vector-processor divide unit.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package vproc_pkg;

    // Operation encoding: bit0 set = unsigned, bit1 set = remainder.
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op;

    function automatic logic op_is_signed(input div_op op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/vproc_div_seq.sv
// Sequential radix-2 restoring divider, RISC-V M DIV/DIVU/REM/REMU semantics.
// Latency: OP_W+2 cycles from accept to out_valid_o; divide-by-zero and signed overflow take 1.
// Backpressure: one op in flight; in_ready_o only in IDLE, result held in DONE until out_ready_i.
module vproc_div_seq
    import vproc_pkg::*;
#(
    parameter int unsigned OP_W  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             async_rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  div_op            in_op_i,
    input  logic [OP_W-1:0]  in_op1_i,
    input  logic [OP_W-1:0]  in_op2_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OP_W-1:0]  out_res_o,
    output logic [TAG_W-1:0] out_tag_o
);

    localparam int unsigned CNT_W = $clog2(OP_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);
    localparam logic [OP_W-1:0]  MOST_NEG = {1'b1, {(OP_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    div_op            op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [OP_W-1:0]  rem_q, rem_d;
    logic [OP_W-1:0]  quo_q, quo_d;
    logic [OP_W-1:0]  dvs_q, dvs_d;
    logic [OP_W-1:0]  res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    // Shared datapath: partial remainder shifted in one bit, minus divisor.
    // rem < divisor always holds, so OP_W+1 bits suffice and the MSB is the sign.
    logic [OP_W:0]    rem_shift;
    logic [OP_W:0]    diff;
    logic             op1_neg, op2_neg, in_signed;
    logic [OP_W-1:0]  fix_sel;
    logic             fix_neg;

    assign rem_shift = {rem_q, quo_q[OP_W-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    assign in_signed = op_is_signed(in_op_i);
    assign op1_neg   = in_signed & in_op1_i[OP_W-1];
    assign op2_neg   = in_signed & in_op2_i[OP_W-1];

    assign fix_sel   = op_is_rem(op_q) ? rem_q : quo_q;
    assign fix_neg   = op_is_signed(op_q) & (op_is_rem(op_q) ? rneg_q : qneg_q);

    assign in_ready_o  = (state_q == IDLE) && !flush_i;
    assign out_valid_o = (state_q == DONE);
    assign out_res_o   = res_q;
    assign out_tag_o   = tag_q;

    // Next-state and datapath update for the accept / iterate / fix-up / hold sequence.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    op_d   = in_op_i;
                    tag_d  = in_tag_i;
                    cnt_d  = '0;
                    qneg_d = op1_neg ^ op2_neg;
                    rneg_d = op1_neg;
                    rem_d  = '0;
                    quo_d  = op1_neg ? -in_op1_i : in_op1_i;
                    dvs_d  = op2_neg ? -in_op2_i : in_op2_i;
                    if (in_op2_i == '0) begin
                        res_d   = op_is_rem(in_op_i) ? in_op1_i : '1;
                        state_d = DONE;
                    end else if (in_signed && (in_op1_i == MOST_NEG) && (in_op2_i == '1)) begin
                        res_d   = op_is_rem(in_op_i) ? '0 : in_op1_i;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // Keep the difference only when it did not go negative.
                quo_d = {quo_q[OP_W-2:0], ~diff[OP_W]};
                rem_d = diff[OP_W] ? rem_shift[OP_W-1:0] : diff[OP_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                res_d   = fix_neg ? -fix_sel : fix_sel;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything, including a result handshake.
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q <= IDLE;
            op_q    <= DIV;
            tag_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

endmodule
